// File: rtl/connect4_win_checker_pkg.sv
// Shared constants and types for the connect-4 win checker and the logic around it.
// Holds the board geometry, the checker FSM encoding and the game-state codes that
// the column-selection logic also uses.
package connect4_win_checker_pkg;

    localparam int BOARD_DIM    = 4;
    localparam int CELLS_NUMBER = BOARD_DIM * BOARD_DIM;
    localparam int NUM_LINES    = 2 * BOARD_DIM + 2;
    localparam int LINE_IDX_W   = 4;

    typedef logic [CELLS_NUMBER-1:0] board_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } chk_state_t;

    typedef enum logic [1:0] {
        GAME_INIT = 2'd0,
        P1_TURN   = 2'd1,
        P2_TURN   = 2'd2,
        END_GAME  = 2'd3
    } game_state_t;

endpackage

// File: rtl/connect4_win_checker_if.sv
// Request/result bundle between the game controller and the win checker.
// master: drives start + board vectors, receives busy/done and the results.
// slave : the checker side of the same bundle.
interface connect4_win_checker_if;
    import connect4_win_checker_pkg::*;

    logic   start;
    board_t gameboard;
    board_t players_cells;
    logic   busy;
    logic   done;
    logic   winner_valid;
    logic   winner;
    board_t win_line;
    logic   draw;

    modport master (
        output start, gameboard, players_cells,
        input  busy, done, winner_valid, winner, win_line, draw
    );

    modport slave (
        input  start, gameboard, players_cells,
        output busy, done, winner_valid, winner, win_line, draw
    );

endinterface

// File: rtl/connect4_win_checker_line_lut.sv
// Combinational map from scan step to the 16-bit cell mask of that winning line.
// Ports: line_idx_i (scan step 0..9), mask_o (cell mask, 0 for unused indices).
// Order: rows 0-3, columns 0-3, diagonal, anti-diagonal.
module connect4_line_lut
    import connect4_win_checker_pkg::*;
(
    input  logic [LINE_IDX_W-1:0] line_idx_i,
    output board_t                mask_o
);

    always_comb begin
        mask_o = '0;
        case (line_idx_i)
            4'd0:    mask_o = 16'h000F;
            4'd1:    mask_o = 16'h00F0;
            4'd2:    mask_o = 16'h0F00;
            4'd3:    mask_o = 16'hF000;
            4'd4:    mask_o = 16'h1111;
            4'd5:    mask_o = 16'h2222;
            4'd6:    mask_o = 16'h4444;
            4'd7:    mask_o = 16'h8888;
            4'd8:    mask_o = 16'h8421;
            4'd9:    mask_o = 16'h1248;
            default: mask_o = '0;
        endcase
    end

endmodule

// File: rtl/connect4_win_checker.sv
// Scans a snapshot of the 4x4 board one winning line per clock and reports winner/draw.
// Ports: clk, reset (async, active-high), bus (slave side of connect4_win_checker_if).
// Hit on line k -> done at T0+k+2, no hit -> done at T0+11; start ignored unless idle.
module connect4_win_checker
    import connect4_win_checker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    connect4_win_checker_if.slave bus
);

    chk_state_t            state_q;
    logic [LINE_IDX_W-1:0] line_idx_q;
    board_t                occ_q;
    board_t                own_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  winner_valid_q;
    logic                  winner_q;
    board_t                win_line_q;
    logic                  draw_q;

    board_t line_mask;
    logic   line_full;
    logic   own_all;
    logic   own_none;
    logic   line_hit;

    connect4_line_lut u_line_lut (
        .line_idx_i (line_idx_q),
        .mask_o     (line_mask)
    );

    always_comb begin
        line_full = ((occ_q & line_mask) == line_mask);
        own_all   = ((own_q & line_mask) == line_mask);
        own_none  = ((own_q & line_mask) == '0);
        // An all-zero mask would look "full"; it never occurs during a scan but keep it inert.
        line_hit  = line_full && (own_all || own_none) && (line_mask != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            line_idx_q     <= '0;
            occ_q          <= '0;
            own_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= 1'b0;
            win_line_q     <= '0;
            draw_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The cycle that shows done is still idle but must not accept a start.
                    if (bus.start && !done_q) begin
                        occ_q          <= bus.gameboard;
                        // Owner bits of empty cells are don't-care; clear them so they can
                        // never reach an output.
                        own_q          <= bus.players_cells & bus.gameboard;
                        line_idx_q     <= '0;
                        winner_valid_q <= 1'b0;
                        winner_q       <= 1'b0;
                        win_line_q     <= '0;
                        draw_q         <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (line_hit) begin
                        winner_valid_q <= 1'b1;
                        winner_q       <= own_all;
                        win_line_q     <= line_mask;
                        busy_q         <= 1'b0;
                        state_q        <= ST_REPORT;
                    end else if (line_idx_q == LINE_IDX_W'(NUM_LINES - 1)) begin
                        draw_q  <= &occ_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_REPORT;
                    end else begin
                        line_idx_q <= line_idx_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.winner       = winner_q;
    assign bus.win_line     = win_line_q;
    assign bus.draw         = draw_q;

endmodule

// File: tb/tb_connect4_win_checker.sv
// Testbench for connect4_win_checker: directed and random boards, scoreboard + monitor.
// Expected results come from a cell-list reference model of the winning lines.
// Covers latency, early exit, draw, ignored starts, snapshot isolation and reset mid-scan.
module tb_connect4_win_checker;
    import connect4_win_checker_pkg::*;

    typedef struct {
        int          lat;
        int          t_done;
        logic        wv;
        logic        w;
        logic [15:0] wl;
        logic        dr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    connect4_win_checker_if bus ();

    connect4_win_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int cell_of(input int l, input int i);
        if (l < 4)       return l * 4 + i;        // row l
        else if (l < 8)  return i * 4 + (l - 4);  // column l-4
        else if (l == 8) return i * 5;            // 0,5,10,15
        else             return 3 + i * 3;        // 3,6,9,12
    endfunction

    function automatic logic [15:0] line_mask(input int l);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[cell_of(l, i)] = 1'b1;
        return m;
    endfunction

    task automatic ref_model(input logic [15:0] occ, input logic [15:0] own, output exp_t e);
        bit found;
        found  = 0;
        e.lat  = 11;
        e.t_done = 0;
        e.wv   = 1'b0;
        e.w    = 1'b0;
        e.wl   = '0;
        e.dr   = (occ == 16'hFFFF);
        for (int l = 0; l < 10; l++) begin
            int ones;
            bit full;
            ones = 0;
            full = 1;
            for (int i = 0; i < 4; i++) begin
                if (occ[cell_of(l, i)] !== 1'b1) full = 0;
                else if (own[cell_of(l, i)] === 1'b1) ones++;
            end
            if (!found && full && (ones == 0 || ones == 4)) begin
                found = 1;
                e.wv  = 1'b1;
                e.w   = (ones == 4);
                e.wl  = line_mask(l);
                e.dr  = 1'b0;
                e.lat = l + 2;
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.t_done);
                    chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
                    chk("winner_valid", {31'd0, bus.winner_valid}, {31'd0, e.wv});
                    chk("winner", {31'd0, bus.winner}, {31'd0, e.w});
                    chk("win_line", {16'd0, bus.win_line}, {16'd0, e.wl});
                    chk("draw", {31'd0, bus.draw}, {31'd0, e.dr});
                    chk("no_x_outputs", {31'd0, $isunknown({bus.winner_valid, bus.winner,
                        bus.win_line, bus.draw, bus.busy})}, 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [15:0] occ, input logic [15:0] own);
        exp_t e;
        @(posedge clk);
        #1;
        bus.gameboard     = occ;
        bus.players_cells = own;
        bus.start         = 1'b1;
        ref_model(occ, own, e);
        e.t_done = cyc + 1 + e.lat;
        sb.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.busy || bus.done) && n < 40);
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle_timeout: got %0d pending results after 40 cycles, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic hold_check();
        chk("hold_winner_valid", {31'd0, bus.winner_valid}, {31'd0, last.wv});
        chk("hold_win_line", {16'd0, bus.win_line}, {16'd0, last.wl});
        chk("hold_draw", {31'd0, bus.draw}, {31'd0, last.dr});
    endtask

    task automatic run_case(input logic [15:0] occ, input logic [15:0] own);
        wait_idle();
        issue(occ, own);
        wait_idle();
        repeat (2) @(negedge clk);
        hold_check();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] own5;
        logic [15:0] occ, own, m;
        exp_t e;

        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.gameboard     = '0;
        bus.players_cells = '0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_winner_valid", {31'd0, bus.winner_valid}, 32'd0);
        chk("rst_winner", {31'd0, bus.winner}, 32'd0);
        chk("rst_win_line", {16'd0, bus.win_line}, 32'd0);
        chk("rst_draw", {31'd0, bus.draw}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed boards
        run_case(16'h000F, 16'h0000);
        run_case(16'h8888, 16'h8888);
        run_case(16'h8421, 16'h0000);
        run_case(16'hFFFF, 16'hC3C3);
        own5 = 16'bxxxx_xxxx_xxxx_0101;
        run_case(16'h000F, own5);
        run_case(16'hFFFF, 16'hFFFF);

        // Start during scan is ignored: one done only, at T0+11
        wait_idle();
        issue(16'hFFFF, 16'hC3C3);            // now at T0 + 1ns
        repeat (2) @(posedge clk);
        #1;
        bus.gameboard = 16'h000F;
        bus.players_cells = 16'h0000;
        bus.start = 1'b1;                     // sampled at T0+3
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        hold_check();

        // Start in the done cycle is ignored, the next cycle's start is accepted
        wait_idle();
        issue(16'h000F, 16'h0000);            // at T0 + 1ns, done visible after T0+2
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.gameboard     = 16'h8888;
        bus.players_cells = 16'h8888;
        bus.start         = 1'b1;
        ref_model(16'h8888, 16'h8888, e);
        e.t_done = cyc + 2 + e.lat;           // accepted at edge cyc+2
        sb.push_back(e);
        last = e;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        hold_check();

        // Reset mid-scan: immediate return to reset values, no done
        wait_idle();
        issue(16'hFFFF, 16'hC3C3);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_winner_valid", {31'd0, bus.winner_valid}, 32'd0);
        chk("midrst_win_line", {16'd0, bus.win_line}, 32'd0);
        chk("midrst_draw", {31'd0, bus.draw}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);           // monitor flags any stray done
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        last.wv = 1'b0;
        last.w  = 1'b0;
        last.wl = '0;
        last.dr = 1'b0;
        hold_check();

        // Random boards, inputs scrambled during the scan
        for (int t = 0; t < 150; t++) begin
            m = line_mask($urandom_range(9));
            case ($urandom_range(3))
                0: occ = 16'($urandom);
                1: occ = 16'hFFFF;
                2: occ = 16'($urandom) | m;
                default: occ = m | line_mask($urandom_range(9));
            endcase
            own = 16'($urandom);
            case ($urandom_range(2))
                0: own = own & ~m;
                1: own = own | m;
                default: ;
            endcase
            wait_idle();
            issue(occ, own);
            repeat (3) begin
                @(posedge clk);
                #1;
                bus.gameboard     = 16'($urandom);
                bus.players_cells = 16'($urandom);
            end
            wait_idle();
            hold_check();
        end

        wait_idle();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
